zext_block_accumulator: RTL and testbench
=========================================

Name: zext_block_accumulator

Overview:
- Downstream consumer of the 4-to-8-bit zero-extender output.
- Accepts a stream of zero-extended 8-bit samples over a valid/ready handshake.
- Accumulates COUNT samples into a block sum and tracks the block maximum.
- Presents the sum and maximum as one result word on an output valid/ready handshake; feeds the next stage (reporting/checksum logic).

Parameters:
- DATA_W, 8, width of incoming zero-extended sample.
- COUNT, 4, samples per block; legal range 2..255.
- SUM_W, 10, accumulator width; must be >= DATA_W + ceil(log2(COUNT)) so overflow is impossible; default covers 4 x 255 = 1020.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous abort: discards the partial block; ignored while a result is held.
- in_valid  in  1  sample present.
- in_data  in  DATA_W  zero-extended sample (upper DATA_W-4 bits are 0 by contract; block does not check).
- in_ready  out  1  block can take a sample.
- out_valid  out  1  result held.
- out_ready  in  1  downstream accepts result.
- out_sum  out  SUM_W  sum of the block's COUNT samples.
- out_max  out  DATA_W  largest sample in the block.
- out_cnt  out  8  number of blocks completed since reset, wrapping at 255 -> 0.

Behaviour:
- Reset (async, rst_n=0): state=ACCUM, acc=0, max=0, idx=0, out_valid=0, out_sum=0, out_max=0, out_cnt=0, in_ready=0 while rst_n low; in_ready=1 from the first clock after release.
- States: ACCUM, HOLD.
- ACCUM:
  - in_ready=1, out_valid=0.
  - A sample is taken on each clock with in_valid&&in_ready.
  - On taking a sample: acc += in_data (zero-extended to SUM_W); max = larger of max and in_data; idx += 1.
  - When the taken sample is the COUNT-th (idx==COUNT-1): next cycle out_sum = final acc, out_max = final max, out_valid=1, out_cnt increments, acc/max/idx clear, state=HOLD.
  - Latency: result is visible on the clock edge after the last sample is taken.
- HOLD:
  - in_ready=0, out_valid=1; out_sum, out_max and out_cnt are stable.
  - On out_valid&&out_ready: out_valid drops next cycle, state=ACCUM, in_ready=1 next cycle.
  - No same-cycle bypass, so at most one sample per 2 cycles at block boundaries.
- clr in ACCUM: acc, max and idx clear at the next edge. A sample offered in the same cycle is consumed (in_ready stays 1) but discarded; clr has priority. out_cnt is unchanged.
- clr in HOLD: no effect.
- in_valid low: state is held indefinitely, with no timeout.
- Samples equal to 0 are counted normally toward COUNT.
- Max ties: value unchanged. First sample of a block always loads max, since max was cleared to 0.
- out_valid must not drop without out_ready (AXI-style rule).
- Reset mid-block or mid-HOLD: everything returns to reset values immediately; the partial result is lost.

Test Plan:
- Reset release, then samples 1,2,3,4 (no backpressure) -> out_valid one cycle after 4th accept, out_sum=10, out_max=4, out_cnt=1; in_ready=0 during HOLD.
- Samples 15,15,15,15 with out_ready held low 5 cycles -> out_sum=60, out_max=15 stable for all 5 cycles; in_valid held high is not accepted; accepted cycle after out_ready=1.
- Samples 3, clr asserted with sample 9, then 5,0,7,2 -> out_sum=14, out_max=7 (3 and 9 discarded).
- Gapped in_valid (1 of every 3 cycles) for samples 8,1,8,0 -> out_sum=17, out_max=8, exactly one result.
- 256 consecutive blocks -> out_cnt wraps 255 -> 0; sums correct each block.
- Assert rst_n=0 in HOLD and separately after 2 samples -> all outputs 0 immediately; next 4 samples form a fresh block.
- Run with DATA_W=8 sweeping all 16 zero-extended input values (0..15) across 4 blocks -> sums 6, 22, 38, 54; maxima 3, 7, 11, 15.

Source files
------------

// File: rtl/zext_block_accumulator_if.sv
// Handshake bundle between the zero-extender stream, the block accumulator and its result consumer.
interface zext_block_accumulator_if #(
  parameter int DATA_W = 8,
  parameter int SUM_W  = 10
);
  logic              clr;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [SUM_W-1:0]  out_sum;
  logic [DATA_W-1:0] out_max;
  logic [7:0]        out_cnt;

  modport master (
    output clr, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_max, out_cnt
  );

  modport slave (
    input  clr, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_max, out_cnt
  );
endinterface

// File: rtl/zext_block_accumulator.sv
// Sums COUNT zero-extended samples per block, tracks the block maximum, and holds the
// result on a valid/ready output until it is taken. Result registers carry a wrapping block count.
module zext_block_accumulator #(
  parameter int DATA_W = 8,
  parameter int COUNT  = 4,
  parameter int SUM_W  = 10
) (
  input logic                    clk,
  input logic                    rst_n,
  zext_block_accumulator_if.slave bus
);

  typedef enum logic {ACCUM, HOLD} state_t;

  localparam logic [7:0] LAST = 8'(COUNT - 1);

  function automatic logic [SUM_W-1:0] acc_add(input logic [SUM_W-1:0]  a,
                                               input logic [DATA_W-1:0] d);
    return a + SUM_W'(d);
  endfunction

  function automatic logic [DATA_W-1:0] max_of(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    return (b > a) ? b : a;
  endfunction

  state_t            state;
  logic [SUM_W-1:0]  acc_p0;
  logic [DATA_W-1:0] max_p0;
  logic [7:0]        idx_p0;
  logic              rdy_p0;

  logic [SUM_W-1:0]  sum_p1;
  logic [DATA_W-1:0] max_p1;
  logic [7:0]        cnt_p1;
  logic              vld_p1;

  logic              take;
  logic [SUM_W-1:0]  acc_next;
  logic [DATA_W-1:0] max_next;

  assign take     = bus.in_valid && rdy_p0;
  assign acc_next = acc_add(acc_p0, bus.in_data);
  assign max_next = max_of(max_p0, bus.in_data);

  // Stage p0: running block sum/max; stage p1: held result word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ACCUM;
      acc_p0 <= '0;
      max_p0 <= '0;
      idx_p0 <= '0;
      rdy_p0 <= 1'b0;
      sum_p1 <= '0;
      max_p1 <= '0;
      cnt_p1 <= '0;
      vld_p1 <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          rdy_p0 <= 1'b1;
          if (bus.clr) begin
            // Abort wins over a concurrent sample: it is accepted but dropped.
            acc_p0 <= '0;
            max_p0 <= '0;
            idx_p0 <= '0;
          end else if (take) begin
            if (idx_p0 == LAST) begin
              sum_p1 <= acc_next;
              max_p1 <= max_next;
              cnt_p1 <= cnt_p1 + 8'd1;
              vld_p1 <= 1'b1;
              rdy_p0 <= 1'b0;
              acc_p0 <= '0;
              max_p0 <= '0;
              idx_p0 <= '0;
              state  <= HOLD;
            end else begin
              acc_p0 <= acc_next;
              max_p0 <= max_next;
              idx_p0 <= idx_p0 + 8'd1;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            vld_p1 <= 1'b0;
            rdy_p0 <= 1'b1;
            state  <= ACCUM;
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = rdy_p0;
  assign bus.out_valid = vld_p1;
  assign bus.out_sum   = sum_p1;
  assign bus.out_max   = max_p1;
  assign bus.out_cnt   = cnt_p1;

endmodule

// File: tb/tb_zext_block_accumulator.sv
// Directed bench for zext_block_accumulator: one task per scenario, expected values hand-computed.
module tb_zext_block_accumulator;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  logic [7:0] exp_cnt;

  zext_block_accumulator_if #(.DATA_W(8), .SUM_W(10)) bus ();

  zext_block_accumulator #(.DATA_W(8), .COUNT(4), .SUM_W(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one sample and return #1 after the edge that accepted it.
  task automatic send(input logic [7:0] d);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!bus.in_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout got in_ready=%0d want 1", bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic send_block(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
    send(a);
    send(b);
    send(c);
    send(d);
  endtask

  task automatic pop();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.clr = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    step();
    vectors++;
    if ({bus.in_ready, bus.out_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_hs got rdy=%0d vld=%0d want 0 0", bus.in_ready, bus.out_valid);
    end
    vectors++;
    if ({bus.out_sum, bus.out_max, bus.out_cnt} !== 26'd0) begin
      miscompares++;
      $display("FAIL reset_data got sum=%0d max=%0d cnt=%0d want 0", bus.out_sum, bus.out_max, bus.out_cnt);
    end
    rst_n = 1'b1;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL release_rdy_early got %0d want 0", bus.in_ready);
    end
    step();
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL release_rdy got %0d want 1", bus.in_ready);
    end
    exp_cnt = 8'd0;
  endtask

  task automatic test_basic();
    bus.out_ready = 1'b1;
    send_block(8'd1, 8'd2, 8'd3, 8'd4);
    exp_cnt++;
    vectors++;
    if ({bus.out_valid, bus.in_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL basic_hs got vld=%0d rdy=%0d want 1 0", bus.out_valid, bus.in_ready);
    end
    vectors++;
    if (bus.out_sum !== 10'd10 || bus.out_max !== 8'd4 || bus.out_cnt !== exp_cnt) begin
      miscompares++;
      $display("FAIL basic_result got sum=%0d max=%0d cnt=%0d want 10 4 %0d", bus.out_sum, bus.out_max, bus.out_cnt, exp_cnt);
    end
    step();
    bus.out_ready = 1'b0;
    vectors++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL basic_release got vld=%0d rdy=%0d want 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_backpressure();
    send_block(8'd15, 8'd15, 8'd15, 8'd15);
    exp_cnt++;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd5;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_sum !== 10'd60 ||
          bus.out_max !== 8'd15 || bus.out_cnt !== exp_cnt) begin
        miscompares++;
        $display("FAIL bp_hold%0d got vld=%0d rdy=%0d sum=%0d max=%0d cnt=%0d want 1 0 60 15 %0d",
                 i, bus.out_valid, bus.in_ready, bus.out_sum, bus.out_max, bus.out_cnt, exp_cnt);
      end
      step();
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    vectors++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL bp_accept got vld=%0d rdy=%0d want 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_clr();
    send(8'd3);
    bus.clr = 1'b1;
    send(8'd9);
    bus.clr = 1'b0;
    send_block(8'd5, 8'd0, 8'd7, 8'd2);
    exp_cnt++;
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== 10'd14 || bus.out_max !== 8'd7 || bus.out_cnt !== exp_cnt) begin
      miscompares++;
      $display("FAIL clr_result got vld=%0d sum=%0d max=%0d cnt=%0d want 1 14 7 %0d",
               bus.out_valid, bus.out_sum, bus.out_max, bus.out_cnt, exp_cnt);
    end
    pop();
  endtask

  task automatic test_gapped();
    logic [7:0] s [4];
    s[0] = 8'd8; s[1] = 8'd1; s[2] = 8'd8; s[3] = 8'd0;
    for (int i = 0; i < 4; i++) begin
      step();
      step();
      vectors++;
      if (bus.out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL gap_early%0d got vld=%0d want 0", i, bus.out_valid);
      end
      send(s[i]);
    end
    exp_cnt++;
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== 10'd17 || bus.out_max !== 8'd8 || bus.out_cnt !== exp_cnt) begin
      miscompares++;
      $display("FAIL gap_result got vld=%0d sum=%0d max=%0d cnt=%0d want 1 17 8 %0d",
               bus.out_valid, bus.out_sum, bus.out_max, bus.out_cnt, exp_cnt);
    end
    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== 10'd17 || bus.out_cnt !== exp_cnt) begin
      miscompares++;
      $display("FAIL clr_in_hold got vld=%0d sum=%0d cnt=%0d want 1 17 %0d",
               bus.out_valid, bus.out_sum, bus.out_cnt, exp_cnt);
    end
    pop();
    for (int i = 0; i < 4; i++) step();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.out_cnt !== exp_cnt) begin
      miscompares++;
      $display("FAIL gap_single got vld=%0d cnt=%0d want 0 %0d", bus.out_valid, bus.out_cnt, exp_cnt);
    end
  endtask

  task automatic test_wrap();
    int a, b, c, d, sum, mx;
    for (int k = 0; k < 256; k++) begin
      a = k % 16; b = (k + 5) % 16; c = (k * 7) % 16; d = 15 - (k % 16);
      sum = a + b + c + d;
      mx = a;
      if (b > mx) mx = b;
      if (c > mx) mx = c;
      if (d > mx) mx = d;
      send_block(8'(a), 8'(b), 8'(c), 8'(d));
      exp_cnt++;
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_sum !== 10'(sum) || bus.out_max !== 8'(mx) || bus.out_cnt !== exp_cnt) begin
        miscompares++;
        $display("FAIL wrap_blk%0d got vld=%0d sum=%0d max=%0d cnt=%0d want 1 %0d %0d %0d",
                 k, bus.out_valid, bus.out_sum, bus.out_max, bus.out_cnt, sum, mx, exp_cnt);
      end
      pop();
    end
  endtask

  task automatic test_reset_mid();
    send_block(8'd9, 8'd9, 8'd9, 8'd9);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.in_ready, bus.out_valid, bus.out_sum, bus.out_max, bus.out_cnt} !== 28'd0) begin
      miscompares++;
      $display("FAIL rst_hold got rdy=%0d vld=%0d sum=%0d max=%0d cnt=%0d want 0",
               bus.in_ready, bus.out_valid, bus.out_sum, bus.out_max, bus.out_cnt);
    end
    rst_n = 1'b1;
    exp_cnt = 8'd0;
    send(8'd12);
    send(8'd13);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.in_ready, bus.out_valid, bus.out_sum, bus.out_max, bus.out_cnt} !== 28'd0) begin
      miscompares++;
      $display("FAIL rst_mid got rdy=%0d vld=%0d sum=%0d max=%0d cnt=%0d want 0",
               bus.in_ready, bus.out_valid, bus.out_sum, bus.out_max, bus.out_cnt);
    end
    rst_n = 1'b1;
    send_block(8'd1, 8'd2, 8'd1, 8'd2);
    exp_cnt++;
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== 10'd6 || bus.out_max !== 8'd2 || bus.out_cnt !== exp_cnt) begin
      miscompares++;
      $display("FAIL rst_fresh got vld=%0d sum=%0d max=%0d cnt=%0d want 1 6 2 %0d",
               bus.out_valid, bus.out_sum, bus.out_max, bus.out_cnt, exp_cnt);
    end
    pop();
  endtask

  task automatic test_sweep();
    int exp_sum [4];
    int exp_max [4];
    exp_sum[0] = 6;  exp_sum[1] = 22; exp_sum[2] = 38; exp_sum[3] = 54;
    exp_max[0] = 3;  exp_max[1] = 7;  exp_max[2] = 11; exp_max[3] = 15;
    for (int blk = 0; blk < 4; blk++) begin
      send_block(8'(4*blk), 8'(4*blk+1), 8'(4*blk+2), 8'(4*blk+3));
      exp_cnt++;
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_sum !== 10'(exp_sum[blk]) ||
          bus.out_max !== 8'(exp_max[blk]) || bus.out_cnt !== exp_cnt) begin
        miscompares++;
        $display("FAIL sweep_blk%0d got vld=%0d sum=%0d max=%0d cnt=%0d want 1 %0d %0d %0d",
                 blk, bus.out_valid, bus.out_sum, bus.out_max, bus.out_cnt,
                 exp_sum[blk], exp_max[blk], exp_cnt);
      end
      pop();
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_clr();
    test_gapped();
    test_wrap();
    test_reset_mid();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
